// File: rtl/filter_read_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : filter_read_sequencer_pkg
// Description : Shared FSM encoding and default widths for the filter read
//               sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package filter_read_sequencer_pkg;

    localparam int c_sp_size      = 8;
    localparam int c_filter_size  = 8;
    localparam int c_pointer_size = 8;
    localparam int c_cnt_w        = 8;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

endpackage : filter_read_sequencer_pkg
`default_nettype wire

// File: rtl/filter_read_sequencer_slot_counter.sv
`default_nettype none
// ============================================================================
// Module      : filter_slot_counter
// Description : Base/offset address generator for one filter slot, including
//               the wrap of the next slot back to address 0.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_slot_counter #(
    parameter int SP_SIZE      = 8,
    parameter int FILTER_SIZE  = 8,
    parameter int POINTER_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    step,
    input  logic                    advance_base,
    input  logic [FILTER_SIZE-1:0]  fs,
    output logic [POINTER_SIZE-1:0] read_pointer,
    output logic                    last_word
);

    // Common working width wide enough for base + 2*fs without overflow.
    localparam int c_w = ((POINTER_SIZE > FILTER_SIZE) ? POINTER_SIZE : FILTER_SIZE) + 2;
    localparam logic [c_w-1:0] c_sp_ext = SP_SIZE[c_w-1:0];

    logic [POINTER_SIZE-1:0] r_base;
    logic [POINTER_SIZE-1:0] r_offset;

    logic [c_w-1:0]          w_fs_ext;
    logic [c_w-1:0]          w_base_ext;
    logic [c_w-1:0]          w_off_ext;
    logic [c_w-1:0]          w_nb;
    logic                    w_wrap;
    logic [POINTER_SIZE-1:0] w_next_base;

    assign w_fs_ext    = {{(c_w-FILTER_SIZE){1'b0}}, fs};
    assign w_base_ext  = {{(c_w-POINTER_SIZE){1'b0}}, r_base};
    assign w_off_ext   = {{(c_w-POINTER_SIZE){1'b0}}, r_offset};
    assign w_nb        = w_base_ext + w_fs_ext;
    assign w_wrap      = (w_nb + w_fs_ext) > c_sp_ext;
    assign w_next_base = w_wrap ? '0 : w_nb[POINTER_SIZE-1:0];

    assign last_word    = (w_off_ext == (w_fs_ext - 1'b1));
    assign read_pointer = r_base + r_offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base   <= '0;
            r_offset <= '0;
        end else if (clear) begin
            r_base   <= '0;
            r_offset <= '0;
        end else if (step) begin
            if (last_word) begin
                r_offset <= '0;
                if (advance_base) begin
                    r_base <= w_next_base;
                end
            end else begin
                r_offset <= r_offset + 1'b1;
            end
        end
    end

endmodule : filter_slot_counter
`default_nettype wire

// File: rtl/filter_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : filter_read_sequencer
// Description : Walks the filter scratchpad one filter per ifmap window,
//               replaying each filter num_windows times across num_filters.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_read_sequencer
    import filter_read_sequencer_pkg::*;
#(
    parameter int SP_SIZE      = c_sp_size,
    parameter int FILTER_SIZE  = c_filter_size,
    parameter int POINTER_SIZE = c_pointer_size,
    parameter int CNT_W        = c_cnt_w
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [FILTER_SIZE-1:0]  filter_size,
    input  logic [CNT_W-1:0]        num_windows,
    input  logic [CNT_W-1:0]        num_filters,
    input  logic                    av_filter,
    input  logic                    mac_ready,
    output logic [POINTER_SIZE-1:0] read_pointer,
    output logic                    rd_en,
    output logic                    co_filter,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);

    localparam logic [FILTER_SIZE:0] c_sp_lim = SP_SIZE[FILTER_SIZE:0];

    logic [1:0]             r_state;
    logic [FILTER_SIZE-1:0] r_fs;
    logic [CNT_W-1:0]       r_nw;
    logic [CNT_W-1:0]       r_nf;
    logic [CNT_W-1:0]       r_win_cnt;
    logic [CNT_W-1:0]       r_flt_cnt;
    logic                   r_cfg_err;

    logic w_cfg_ok;
    logic w_idle;
    logic w_accept;
    logic w_last_word;
    logic w_win_last;
    logic w_flt_last;

    assign w_cfg_ok = (filter_size != '0) && (num_windows != '0) && (num_filters != '0)
                   && ({1'b0, filter_size} <= c_sp_lim);
    assign w_idle   = (r_state == c_st_idle);
    assign w_accept = w_idle && start && w_cfg_ok;

    assign w_win_last = (r_win_cnt == (r_nw - 1'b1));
    assign w_flt_last = (r_flt_cnt == (r_nf - 1'b1));

    assign rd_en     = (r_state == c_st_run) && av_filter && mac_ready;
    assign co_filter = rd_en && w_last_word;
    assign busy      = !w_idle;
    assign done      = (r_state == c_st_done);
    assign cfg_err   = r_cfg_err;

    filter_slot_counter #(
        .SP_SIZE      (SP_SIZE),
        .FILTER_SIZE  (FILTER_SIZE),
        .POINTER_SIZE (POINTER_SIZE)
    ) u_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (w_accept),
        .step         (rd_en),
        .advance_base (w_win_last),
        .fs           (r_fs),
        .read_pointer (read_pointer),
        .last_word    (w_last_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_fs      <= '0;
            r_nw      <= '0;
            r_nf      <= '0;
            r_win_cnt <= '0;
            r_flt_cnt <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_idle && start && !w_cfg_ok;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_fs      <= filter_size;
                        r_nw      <= num_windows;
                        r_nf      <= num_filters;
                        r_win_cnt <= '0;
                        r_flt_cnt <= '0;
                        r_state   <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (co_filter) begin
                        if (!w_win_last) begin
                            r_win_cnt <= r_win_cnt + 1'b1;
                        end else begin
                            r_win_cnt <= '0;
                            r_flt_cnt <= r_flt_cnt + 1'b1;
                            if (w_flt_last) begin
                                r_state <= c_st_done;
                            end
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule : filter_read_sequencer
`default_nettype wire

// File: tb/tb_filter_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_filter_read_sequencer
// Description : Scoreboard bench for filter_read_sequencer (SP_SIZE = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_read_sequencer;

    localparam int c_sp = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] filter_size = '0;
    logic [7:0] num_windows = '0;
    logic [7:0] num_filters = '0;
    logic       av_filter = 1'b0;
    logic       mac_ready = 1'b0;
    logic [7:0] read_pointer;
    logic       rd_en;
    logic       co_filter;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int checks   = 0;
    int failures = 0;

    // Each entry: {co_filter, read_pointer} expected on one transfer.
    logic [8:0] sb_q[$];

    filter_read_sequencer #(
        .SP_SIZE      (c_sp),
        .FILTER_SIZE  (8),
        .POINTER_SIZE (8),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .filter_size  (filter_size),
        .num_windows  (num_windows),
        .num_filters  (num_filters),
        .av_filter    (av_filter),
        .mac_ready    (mac_ready),
        .read_pointer (read_pointer),
        .rd_en        (rd_en),
        .co_filter    (co_filter),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_model(input int fs, input int nw, input int nf);
        int base;
        int nb;
        base = 0;
        for (int f = 0; f < nf; f++) begin
            for (int w = 0; w < nw; w++) begin
                for (int o = 0; o < fs; o++) begin
                    sb_q.push_back({(o == fs - 1) ? 1'b1 : 1'b0, 8'(base + o)});
                end
            end
            nb = base + fs;
            base = (nb + fs > c_sp) ? 0 : nb;
        end
    endtask

    task automatic drive_start(input int fs, input int nw, input int nf);
        @(posedge clk) #1;
        start       = 1'b1;
        filter_size = 8'(fs);
        num_windows = 8'(nw);
        num_filters = 8'(nf);
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic bad_start(input string tag, input int fs, input int nw, input int nf);
        drive_start(fs, nw, nf);
        @(negedge clk);
        check_eq({tag, "_cfg_err"}, cfg_err, 1);
        check_eq({tag, "_busy"}, busy, 0);
        @(posedge clk) #1;
        @(negedge clk);
        check_eq({tag, "_cfg_err_pulse"}, cfg_err, 0);
    endtask

    // mode 0: always ready; 1: av low cycles 2-3, mac_ready low cycle 5; 2: random.
    task automatic run_job(input int fs, input int nw, input int nf, input int mode, input bit poke);
        int         cyc;
        bit         ended;
        logic [8:0] e;
        cyc   = 0;
        ended = 1'b0;
        push_model(fs, nw, nf);
        drive_start(fs, nw, nf);
        while (!ended && cyc < 400) begin
            cyc++;
            case (mode)
                1: begin
                    av_filter = !(cyc == 2 || cyc == 3);
                    mac_ready = (cyc != 5);
                end
                2: begin
                    av_filter = ($urandom_range(0, 3) != 0);
                    mac_ready = ($urandom_range(0, 3) != 0);
                end
                default: begin
                    av_filter = 1'b1;
                    mac_ready = 1'b1;
                end
            endcase
            if (poke && cyc == 2) begin
                start       = 1'b1;
                filter_size = 8'd2;
                num_windows = 8'd1;
                num_filters = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (cyc == 1) check_eq("busy_run", busy, 1);
            check_eq("rd_en_gate", rd_en, av_filter & mac_ready);
            check_eq("cfg_err_run", cfg_err, 0);
            check_eq("done_early", done, 0);
            if (rd_en) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", rd_en, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("read_pointer", read_pointer, e[7:0]);
                    check_eq("co_filter", co_filter, e[8]);
                    if (sb_q.size() == 0) ended = 1'b1;
                end
            end else begin
                check_eq("co_no_xfer", co_filter, 0);
            end
            @(posedge clk) #1;
        end
        start = 1'b0;
        if (!ended) begin
            check_eq("timeout_left", sb_q.size(), 0);
            sb_q.delete();
        end else begin
            @(negedge clk);
            check_eq("done_pulse", done, 1);
            check_eq("rd_en_done", rd_en, 0);
            @(posedge clk) #1;
            @(negedge clk);
            check_eq("done_clear", done, 0);
            check_eq("busy_end", busy, 0);
        end
        av_filter = 1'b0;
        mac_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ptr", read_pointer, 0);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        @(posedge clk) #1;
        check_eq("rel_busy", busy, 0);
        check_eq("rel_cfg_err", cfg_err, 0);

        run_job(3, 2, 1, 0, 1'b0);
        run_job(3, 1, 3, 0, 1'b0);
        run_job(4, 1, 1, 1, 1'b0);

        bad_start("fs0", 0, 1, 1);
        bad_start("nw0", 3, 0, 1);
        bad_start("fs9", 9, 1, 1);
        bad_start("nf0", 3, 1, 0);

        // Reset mid-run after two transfers (offset = 2)
        drive_start(4, 2, 1);
        av_filter = 1'b1;
        mac_ready = 1'b1;
        @(negedge clk);
        check_eq("mid_ptr0", read_pointer, 0);
        @(posedge clk) #1;
        @(negedge clk);
        check_eq("mid_ptr1", read_pointer, 1);
        @(posedge clk) #1;
        @(negedge clk);
        check_eq("mid_ptr2", read_pointer, 2);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_rd_en", rd_en, 0);
        check_eq("arst_ptr", read_pointer, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_co", co_filter, 0);
        check_eq("arst_done", done, 0);
        av_filter = 1'b0;
        mac_ready = 1'b0;
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arel_busy", busy, 0);
        check_eq("arel_done", done, 0);
        run_job(3, 1, 1, 0, 1'b0);

        run_job(1, 3, 2, 0, 1'b1);
        run_job(5, 2, 3, 2, 1'b0);
        run_job(2, 3, 4, 2, 1'b0);
        run_job(8, 1, 2, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_filter_read_sequencer
`default_nettype wire
